// File: rtl/load_writeback_unit_pkg.sv
// Shared types and helpers for the load/writeback path.
//   state_t   : load unit FSM states
//   SZ_*      : request size codes (also the register file write_en codes)
//   lane_sel  : big-endian byte-lane select for a size/offset pair
package bexkat_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Offset 0 is the most significant lane (data[31:24]).
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b1000 >> off;
            SZ_HALF: sel = off[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational extraction of the addressed byte/halfword/word from a
// big-endian bus word, right-justified and zero-extended.
//   dat_i    : raw bus read data
//   size_i   : size code (byte/half/word)
//   offset_i : byte offset within the word (addr[1:0])
//   data_o   : aligned, zero-extended result
module load_align
    import bexkat_load_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dat_i,
    input  logic [1:0]       size_i,
    input  logic [1:0]       offset_i,
    output logic [WIDTH-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = dat_i[31:24];
            2'd1:    byte_lane = dat_i[23:16];
            2'd2:    byte_lane = dat_i[15:8];
            default: byte_lane = dat_i[7:0];
        endcase
        half_lane = offset_i[1] ? dat_i[15:0] : dat_i[31:16];
    end

    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{(WIDTH-8){1'b0}}, byte_lane};
            SZ_HALF: data_o = {{(WIDTH-16){1'b0}}, half_lane};
            default: data_o = dat_i;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Load stage feeding the register file write port. Takes one load request,
// runs a single cyc/stb/ack bus read, aligns the result and writes it back
// for one cycle. Bus error, misalignment and timeout give a fault pulse.
//   req_*    : load request handshake (accepted only in IDLE)
//   bus_*    : bus master read port (word addressed, byte lane selects)
//   rf_*     : register file write port (write_en carries the size code)
//   done_o   : one-cycle pulse on a completed writeback
//   fault_o  : one-cycle pulse on a rejected or failed request
//   busy_o   : state is not IDLE
//
// state | meaning
// IDLE  | ready for a request; misaligned/illegal requests fault here
// BUS   | bus cycle in flight, waiting for ack/err/timeout
// WB    | register file write presented for one cycle
module load_writeback_unit
    import bexkat_load_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNTP  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [WIDTH-1:0]  req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic [COUNTP-1:0] req_dest_i,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [WIDTH-1:0]  bus_adr_o,
    output logic [3:0]        bus_sel_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,
    output logic [COUNTP-1:0] rf_write_addr_o,
    output logic [WIDTH-1:0]  rf_write_data_o,
    output logic [1:0]        rf_write_en_o,
    output logic              done_o,
    output logic              fault_o,
    output logic              busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic [WIDTH-1:0]  adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic [COUNTP-1:0] dest_q, dest_d;
    logic [COUNTP-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [1:0]        we_q, we_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic [WIDTH-1:0]  aligned;
    logic              misaligned;
    logic              timed_out;

    load_align #(.WIDTH(WIDTH)) u_align (
        .dat_i    (bus_dat_i),
        .size_i   (size_q),
        .offset_i (off_q),
        .data_o   (aligned)
    );

    always_comb begin
        misaligned = (req_size_i == 2'b00)
                  || (req_size_i == SZ_HALF && req_addr_i[0])
                  || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
    end

    // Last permitted wait cycle: the counter starts at 0 on the first BUS cycle.
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            dest_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            size_q  <= size_d;
            dest_q  <= dest_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = 1'b0;
        adr_d   = adr_q;
        sel_d   = sel_q;
        off_d   = off_q;
        size_d  = size_q;
        dest_d  = dest_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 2'b00;
        done_d  = 1'b0;
        fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        adr_d   = {req_addr_i[WIDTH-1:2], 2'b00};
                        sel_d   = lane_sel(req_size_i, req_addr_i[1:0]);
                        off_d   = req_addr_i[1:0];
                        size_d  = req_size_i;
                        dest_d  = req_dest_i;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (bus_err_i || (!bus_ack_i && timed_out)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else if (bus_ack_i) begin
                    we_d    = size_q;
                    waddr_d = dest_q;
                    wdata_d = aligned;
                    done_d  = 1'b1;
                    state_d = WB;
                end else begin
                    cyc_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign bus_cyc_o       = cyc_q;
    assign bus_stb_o       = cyc_q;
    assign bus_we_o        = 1'b0;
    assign bus_adr_o       = adr_q;
    assign bus_sel_o       = sel_q;
    assign rf_write_addr_o = waddr_q;
    assign rf_write_data_o = wdata_q;
    assign rf_write_en_o   = we_q;
    assign done_o          = done_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_load_writeback_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic [3:0]  req_dest_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [3:0]  rf_write_addr_o;
    logic [31:0] rf_write_data_o;
    logic [1:0]  rf_write_en_o;
    logic        done_o;
    logic        fault_o;
    logic        busy_o;

    int n_pass  = 0;
    int n_total = 0;

    load_writeback_unit #(.WIDTH(32), .COUNTP(4), .TIMEOUT(255)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_size_i      (req_size_i),
        .req_dest_i      (req_dest_i),
        .bus_cyc_o       (bus_cyc_o),
        .bus_stb_o       (bus_stb_o),
        .bus_we_o        (bus_we_o),
        .bus_adr_o       (bus_adr_o),
        .bus_sel_o       (bus_sel_o),
        .bus_dat_i       (bus_dat_i),
        .bus_ack_i       (bus_ack_i),
        .bus_err_i       (bus_err_i),
        .rf_write_addr_o (rf_write_addr_o),
        .rf_write_data_o (rf_write_data_o),
        .rf_write_en_o   (rf_write_en_o),
        .done_o          (done_o),
        .fault_o         (fault_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic request(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] dest);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_size_i  = size;
        req_dest_i  = dest;
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_size_i  = '0;
        req_dest_i  = '0;
        bus_dat_i   = '0;
        bus_ack_i   = 1'b0;
        bus_err_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);

        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_cyc", {30'd0, bus_cyc_o, bus_stb_o}, 32'd0);
        chk("rst_we", {30'd0, rf_write_en_o}, 32'd0);
        chk("rst_flags", {29'd0, done_o, fault_o, busy_o}, 32'd0);
        chk("rst_adr", bus_adr_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // Byte at 0x1002, ack on first bus cycle
        request(32'h1002, 2'b01, 4'd5);
        tick();
        req_valid_i = 1'b0;
        chk("b1_cyc", {30'd0, bus_cyc_o, bus_stb_o}, 32'd3);
        chk("b1_adr", bus_adr_o, 32'h1000);
        chk("b1_sel", {28'd0, bus_sel_o}, 32'b0010);
        chk("b1_we_bus", {31'd0, bus_we_o}, 32'd0);
        chk("b1_ready", {30'd0, req_ready_o, busy_o}, 32'b01);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hAABBCCDD;
        tick();
        bus_ack_i = 1'b0;
        chk("b1_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
        chk("b1_wen", {30'd0, rf_write_en_o}, 32'b01);
        chk("b1_waddr", {28'd0, rf_write_addr_o}, 32'd5);
        chk("b1_wdata", rf_write_data_o, 32'h000000CC);
        chk("b1_done", {30'd0, done_o, fault_o}, 32'b10);
        tick();
        chk("b1_after", {28'd0, rf_write_en_o, done_o, req_ready_o}, 32'b0001);
        chk("b1_hold", rf_write_data_o, 32'h000000CC);

        // Halfword at 0x2002 with three wait states
        request(32'h2002, 2'b10, 4'd15);
        tick();
        req_valid_i = 1'b0;
        chk("h1_sel", {28'd0, bus_sel_o}, 32'b0011);
        for (int i = 0; i < 3; i++) begin
            chk("h1_wait", {29'd0, bus_cyc_o, bus_stb_o, req_ready_o}, 32'b110);
            tick();
        end
        chk("h1_cyc4", {30'd0, bus_cyc_o, req_ready_o}, 32'b10);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h12345678;
        tick();
        bus_ack_i = 1'b0;
        chk("h1_wen", {30'd0, rf_write_en_o}, 32'b10);
        chk("h1_wdata", rf_write_data_o, 32'h00005678);
        chk("h1_waddr", {28'd0, rf_write_addr_o}, 32'd15);
        chk("h1_cyc_drop", {30'd0, bus_cyc_o, req_ready_o}, 32'b00);
        tick();

        // Misaligned word and illegal size: fault only
        request(32'h3001, 2'b11, 4'd1);
        tick();
        req_valid_i = 1'b0;
        chk("mw_fault", {28'd0, fault_o, bus_cyc_o, done_o, busy_o}, 32'b1000);
        chk("mw_wen", {30'd0, rf_write_en_o}, 32'd0);
        chk("mw_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        chk("mw_pulse", {30'd0, fault_o, bus_cyc_o}, 32'd0);
        request(32'h3000, 2'b00, 4'd1);
        tick();
        req_valid_i = 1'b0;
        chk("sz0_fault", {29'd0, fault_o, bus_cyc_o, rf_write_en_o != 2'b00}, 32'b100);
        tick();

        // Aligned word at 0x3000
        request(32'h3000, 2'b11, 4'd3);
        tick();
        req_valid_i = 1'b0;
        chk("w1_sel", {28'd0, bus_sel_o}, 32'b1111);
        chk("w1_adr", bus_adr_o, 32'h3000);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hDEADBEEF;
        tick();
        bus_ack_i = 1'b0;
        chk("w1_wen", {30'd0, rf_write_en_o}, 32'b11);
        chk("w1_wdata", rf_write_data_o, 32'hDEADBEEF);
        chk("w1_waddr", {28'd0, rf_write_addr_o}, 32'd3);
        tick();

        // Byte at offset 0 (most significant lane)
        request(32'h4000, 2'b01, 4'd8);
        tick();
        req_valid_i = 1'b0;
        chk("b0_sel", {28'd0, bus_sel_o}, 32'b1000);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'h11223344;
        tick();
        bus_ack_i = 1'b0;
        chk("b0_wdata", rf_write_data_o, 32'h00000011);
        tick();

        // err and ack together: err wins
        request(32'h4003, 2'b01, 4'd7);
        tick();
        req_valid_i = 1'b0;
        chk("e1_sel", {28'd0, bus_sel_o}, 32'b0001);
        bus_ack_i = 1'b1;
        bus_err_i = 1'b1;
        bus_dat_i = 32'h55667788;
        tick();
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        chk("e1_fault", {29'd0, fault_o, done_o, bus_cyc_o}, 32'b100);
        chk("e1_wen", {30'd0, rf_write_en_o}, 32'd0);
        chk("e1_hold", rf_write_data_o, 32'h00000011);
        chk("e1_idle", {30'd0, busy_o, req_ready_o}, 32'b01);
        tick();

        // Timeout: no ack for 255 bus cycles
        request(32'h5001, 2'b01, 4'd2);
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (bus_cyc_o && n < 400) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 32'd255);
        chk("to_fault", {29'd0, fault_o, done_o, rf_write_en_o != 2'b00}, 32'b100);
        tick();
        chk("to_pulse", {30'd0, fault_o, req_ready_o}, 32'b01);

        // Asynchronous reset during BUS
        request(32'h6000, 2'b10, 4'd9);
        tick();
        req_valid_i = 1'b0;
        chk("rb_cyc", {31'd0, bus_cyc_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rb_async", {30'd0, bus_cyc_o, bus_stb_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rb_ready", {30'd0, req_ready_o, busy_o}, 32'b10);
        chk("rb_wdata", rf_write_data_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus_ack_i = 1'b1;
            tick();
            chk("rb_quiet", {27'd0, rf_write_en_o, done_o, fault_o, bus_cyc_o}, 32'd0);
        end
        bus_ack_i = 1'b0;

        // Back-to-back with valid held high
        request(32'h7001, 2'b01, 4'd4);
        tick();
        request(32'h7000, 2'b10, 4'd6);
        chk("bb1_ready", {31'd0, req_ready_o}, 32'd0);
        chk("bb1_sel", {28'd0, bus_sel_o}, 32'b0100);
        chk("bb1_adr", bus_adr_o, 32'h7000);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hAABBCCDD;
        tick();
        bus_ack_i = 1'b0;
        chk("bb1_wb", {22'd0, rf_write_addr_o, rf_write_en_o, req_ready_o, done_o, 2'b00}, {22'd0, 4'd4, 2'b01, 1'b0, 1'b1, 2'b00});
        chk("bb1_wdata", rf_write_data_o, 32'h000000BB);
        tick();
        chk("bb2_accept", {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("bb2_bus", {28'd0, bus_sel_o}, 32'b1100);
        chk("bb2_ready", {30'd0, req_ready_o, bus_cyc_o}, 32'b01);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("bb2_waddr", {28'd0, rf_write_addr_o}, 32'd6);
        chk("bb2_wen", {30'd0, rf_write_en_o}, 32'b10);
        chk("bb2_wdata", rf_write_data_o, 32'h0000AABB);
        tick();
        chk("bb2_idle", {29'd0, req_ready_o, done_o, bus_cyc_o}, 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Load stage directly upstream of the CPU register file write port.
- Accepts one load request at a time and runs a single bus read cycle (cyc/stb/ack).
- Extracts the addressed byte, halfword or word and right-justifies it.
- Drives the register file's write_addr/write_data/write_en port for exactly one cycle.
- Reports bus errors, misalignment and bus timeouts as a one-cycle fault pulse.

Parameters:
- WIDTH, 32, data and address width. Only 32 is supported.
- COUNTP, 4, register index width.
- TIMEOUT, 255, number of BUS-state cycles without ack/err before the cycle is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. Asynchronous, active-high.
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  unit can accept a request. High only in IDLE.
- req_addr_i  in  WIDTH  byte address
- req_size_i  in  2  01=byte, 10=halfword, 11=word, 00=illegal
- req_dest_i  in  COUNTP  destination register
- bus_cyc_o  out  1  bus cycle active
- bus_stb_o  out  1  strobe
- bus_we_o  out  1  always 0
- bus_adr_o  out  WIDTH  word address. Bits [1:0] forced to 0.
- bus_sel_o  out  4  byte lane select
- bus_dat_i  in  WIDTH  read data
- bus_ack_i  in  1  cycle complete
- bus_err_i  in  1  cycle error
- rf_write_addr_o  out  COUNTP  to register file write_addr
- rf_write_data_o  out  WIDTH  to register file write_data
- rf_write_en_o  out  2  to register file write_en. Size code; 00 = no write.
- done_o  out  1  one-cycle pulse on successful writeback
- fault_o  out  1  one-cycle pulse on a failed request
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values: all outputs 0 except req_ready_o=1. State IDLE, timeout counter 0.
- Reset mid-cycle drops cyc/stb immediately (asynchronously); no writeback, no fault.
- All outputs are registered except req_ready_o and busy_o, which decode the state.
- Byte order is big-endian. Address offset 0 maps to data[31:24].
- Lane selects:
  - byte: sel = 1000 >> addr[1:0]
  - halfword: addr[1]=0 gives 1100, addr[1]=1 gives 0011
  - word: 1111
- States:
  - IDLE
    - Handshake occurs when req_valid_i & req_ready_o in cycle N.
    - Illegal size (00), halfword with addr[0]=1, or word with addr[1:0]!=0: fault_o=1 in N+1, stay IDLE, no bus activity.
    - Otherwise latch addr, size and dest; enter BUS. cyc/stb/adr/sel are valid from N+1.
  - BUS
    - cyc and stb are held high until ack or err. The counter increments each cycle.
    - ack_i in cycle M: capture the lane and right-justify it, zero-extended. Byte = lane >> ((3-addr[1:0])*8); halfword = addr[1] ? dat[15:0] : dat[31:16].
    - On ack_i in M: drop cyc/stb in M+1 and enter WB.
    - err_i in M (priority over ack if both are high): drop cyc/stb, fault_o=1 in M+1, return to IDLE.
    - Counter reaches TIMEOUT with no ack/err: same as err.
  - WB
    - In cycle M+1: rf_write_en_o = latched size, rf_write_addr_o = dest, rf_write_data_o = extracted data, done_o=1.
    - Return to IDLE in M+2.
- Best-case load latency: accept N, ack N+1, register write N+2, next accept N+3.
- rf_write_en_o is 00 outside WB. rf_write_data_o holds its last value.
- The unit never writes through a different size code than the request carried.
- req_* inputs are ignored while not IDLE.
- fault_o and done_o are never high in the same cycle.

Decomposition:
- Package bexkat_load_pkg:
  - state enum {IDLE, BUS, WB}
  - size constants SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b11
  - function lane_sel(size, addr[1:0]) returning the 4-bit select
- Sub-module load_align (combinational): inputs bus_dat_i, size, addr[1:0]; output right-justified zero-extended data. Reused later by the store path for the inverse mapping.

Test Plan:
- Byte at 0x1002, dest 5, dat=0xAABBCCDD, ack one cycle after stb -> sel=0010, adr=0x1000, WB write_en=01, write_addr=5, write_data=0x000000CC, done pulse.
- Halfword at 0x2002, dest 15, dat=0x12345678 with 3 wait states -> cyc held 4 cycles, write_en=10, write_data=0x00005678; req_ready low throughout.
- Word at 0x3001 -> fault_o pulse next cycle, bus_cyc_o never asserted, rf_write_en_o stays 00; then a word load at 0x3000 with dat=0xDEADBEEF -> write_data=0xDEADBEEF, write_en=11.
- Byte load with err_i and ack_i high together -> fault_o=1, no done, no register write; no ack within TIMEOUT=255 -> abort at cycle 255 with fault_o.
- rst_i asserted while in BUS -> cyc/stb low immediately; after release req_ready_o=1 and no spurious write_en or done.
- Back-to-back requests with valid held high -> second accepted only in IDLE; writebacks occur in order with correct dest for each.
